// File: rtl/booth_pkg.sv
// Shared types and helpers for the radix-4 Booth sequential multiplier:
// FSM states, Booth digit encoding, digit recoder and the 4:2 compressor cell.
package booth_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACCUM   = 2'd1,
    RESOLVE = 2'd2,
    DONE    = 2'd3
  } state_e;

  typedef enum logic [2:0] {
    ZERO = 3'd0,
    POS1 = 3'd1,
    POS2 = 3'd2,
    NEG1 = 3'd3,
    NEG2 = 3'd4
  } booth_digit_e;

  typedef struct packed {
    logic sum;
    logic carry;
    logic cout;
  } cell_out_t;

  // bits = {b[2i+1], b[2i], b[2i-1]}
  function automatic booth_digit_e booth_recode(input logic [2:0] bits);
    booth_digit_e d;
    case (bits)
      3'b000, 3'b111: d = ZERO;
      3'b001, 3'b010: d = POS1;
      3'b011:         d = POS2;
      3'b100:         d = NEG2;
      3'b101, 3'b110: d = NEG1;
      default:        d = ZERO;
    endcase
    return d;
  endfunction

  // cout depends only on x0..x2, so the inter-column chain never ripples.
  function automatic cell_out_t cmp42_cell(input logic x0, input logic x1,
                                           input logic x2, input logic x3,
                                           input logic cin);
    cell_out_t r;
    logic      s1;
    s1      = x0 ^ x1 ^ x2;
    r.cout  = (x0 & x1) | (x0 & x2) | (x1 & x2);
    r.sum   = s1 ^ x3 ^ cin;
    r.carry = (s1 & x3) | (s1 & cin) | (x3 & cin);
    return r;
  endfunction

endpackage

// File: rtl/compressor_4_2_row.sv
// N-bit row of 4:2 compressor cells. carry[j] carries weight 2^(j+1); the
// caller aligns it. The chain carry out of the top column is dropped.
module compressor_4_2_row
  import booth_pkg::*;
#(
  parameter int N = 32
) (
  input  logic [N-1:0] in0,
  input  logic [N-1:0] in1,
  input  logic [N-1:0] in2,
  input  logic [N-1:0] in3,
  output logic [N-1:0] sum,
  output logic [N-1:0] carry
);

  cell_out_t cell_s;
  logic      chain_s;

  // Walk the columns LSB first, passing each cell's cout into the next column.
  always_comb begin
    sum     = '0;
    carry   = '0;
    chain_s = 1'b0;
    cell_s  = '0;
    for (int j = 0; j < N; j++) begin
      cell_s   = cmp42_cell(in0[j], in1[j], in2[j], in3[j], chain_s);
      sum[j]   = cell_s.sum;
      carry[j] = cell_s.carry;
      chain_s  = cell_s.cout;
    end
  end

endmodule

// File: rtl/booth_seq_mul_ctrl.sv
// Sequential radix-4 Booth multiplier: two Booth digits per ACCUM cycle are
// folded into a redundant sum/carry pair, resolved by one final adder.
module booth_seq_mul_ctrl
  import booth_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   p,
  output logic                 busy
);

  localparam int PW    = 2 * WIDTH;
  localparam int NITER = WIDTH / 4;
  localparam int CW    = (NITER > 1) ? $clog2(NITER) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(NITER - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [PW-1:0] PW_ONE   = PW'(1);

  state_e            state_q, state_d;
  logic [WIDTH-1:0]  a_q, a_d;
  logic [WIDTH-1:0]  b_q, b_d;
  logic [PW-1:0]     sum_q, sum_d;
  logic [PW-1:0]     carry_q, carry_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [PW-1:0]     p_q, p_d;
  logic              in_ready_q, in_ready_d;
  logic              out_valid_q, out_valid_d;
  logic              busy_q, busy_d;

  logic [WIDTH:0]    b_ext;
  booth_digit_e      dig_lo, dig_hi;
  logic [PW-1:0]     pp_lo, pp_hi;
  logic [PW-1:0]     row_sum, row_carry;

  function automatic logic [PW-1:0] pp_gen(input booth_digit_e d,
                                           input logic [WIDTH-1:0] x,
                                           input logic [CW+1:0] sh);
    logic [PW-1:0] xe;
    logic [PW-1:0] m;
    xe = {{WIDTH{x[WIDTH-1]}}, x};
    case (d)
      ZERO:    m = '0;
      POS1:    m = xe;
      POS2:    m = xe << 1;
      NEG1:    m = ~xe + PW_ONE;
      NEG2:    m = ~(xe << 1) + PW_ONE;
      default: m = '0;
    endcase
    return m << sh;
  endfunction

  // b_ext[0] stands in for b[-1]; iteration k reads digits 2k and 2k+1.
  always_comb begin
    b_ext  = {b_q, 1'b0};
    dig_lo = booth_recode(b_ext[{cnt_q, 2'b00} +: 3]);
    dig_hi = booth_recode(b_ext[{cnt_q, 2'b10} +: 3]);
    pp_lo  = pp_gen(dig_lo, a_q, {cnt_q, 2'b00});
    pp_hi  = pp_gen(dig_hi, a_q, {cnt_q, 2'b10});
  end

  compressor_4_2_row #(
    .N (PW)
  ) u_row (
    .in0   (sum_q),
    .in1   (carry_q),
    .in2   (pp_lo),
    .in3   (pp_hi),
    .sum   (row_sum),
    .carry (row_carry)
  );

  // Next-state, datapath register updates and registered handshake outputs.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    p_d     = p_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d     = a;
          b_d     = b;
          sum_d   = '0;
          carry_d = '0;
          cnt_d   = '0;
          state_d = ACCUM;
        end else begin
          state_d = IDLE;
        end
      end
      ACCUM: begin
        sum_d   = row_sum;
        carry_d = row_carry << 1;
        if (cnt_q == CNT_LAST) begin
          cnt_d   = cnt_q;
          state_d = RESOLVE;
        end else begin
          cnt_d   = cnt_q + CNT_ONE;
          state_d = ACCUM;
        end
      end
      RESOLVE: begin
        p_d     = sum_q + carry_q;
        state_d = DONE;
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end else begin
          state_d = DONE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    in_ready_d  = (state_d == IDLE);
    out_valid_d = (state_d == DONE);
    busy_d      = (state_d != IDLE);
  end

  // State and datapath registers; rst overrides any handshake in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      a_q         <= '0;
      b_q         <= '0;
      sum_q       <= '0;
      carry_q     <= '0;
      cnt_q       <= '0;
      p_q         <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      sum_q       <= sum_d;
      carry_q     <= carry_d;
      cnt_q       <= cnt_d;
      p_q         <= p_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign p         = p_q;

endmodule

// File: tb/tb_booth_seq_mul_ctrl.sv
// Directed and randomised checks of booth_seq_mul_ctrl (WIDTH=16) against
// hand-computed products and a signed multiply reference.
module tb_booth_seq_mul_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] a;
  logic [15:0] b;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] p;
  logic        busy;

  int vectors     = 0;
  int miscompares = 0;
  int cyc         = 0;

  booth_seq_mul_ctrl #(
    .WIDTH (16)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .p         (p),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_vec(input string tag, input logic [63:0] obs,
                           input logic [63:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Present one operand pair, collect the product, let it be consumed.
  task automatic run_op(input logic [15:0] ai, input logic [15:0] bi,
                        output logic [31:0] pr, output int lat);
    @(negedge clk);
    a         = ai;
    b         = bi;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat      = 0;
    while (out_valid !== 1'b1 && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    pr = p;
    @(posedge clk); #1;
  endtask

  logic [15:0] dir_a [10] = '{16'h0003, 16'h8000, 16'hFFFF, 16'h7FFF, 16'h7FFF,
                              16'h8000, 16'h0000, 16'h1234, 16'hFFFF, 16'h8000};
  logic [15:0] dir_b [10] = '{16'h0005, 16'h8000, 16'h0001, 16'h8000, 16'h7FFF,
                              16'h7FFF, 16'h1234, 16'h0002, 16'hFFFF, 16'h0001};
  logic [31:0] dir_p [10] = '{32'h0000000F, 32'h40000000, 32'hFFFFFFFF,
                              32'hC0008000, 32'h3FFF0001, 32'hC0008000,
                              32'h00000000, 32'h00002468, 32'h00000001,
                              32'hFFFF8000};

  initial begin
    logic [31:0]        pr;
    int                 lat;
    int                 t;
    int                 acc_c;
    int                 prev_c;
    logic               seen;
    logic [15:0]        ai;
    logic [15:0]        bi;
    logic signed [31:0] sa;
    logic signed [31:0] sb;
    logic [31:0]        expv;

    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    a         = 16'h0000;
    b         = 16'h0000;
    repeat (3) @(posedge clk);
    #1;
    check_vec("rst_in_ready", 64'(in_ready), 64'd1);
    check_vec("rst_out_valid", 64'(out_valid), 64'd0);
    check_vec("rst_busy", 64'(busy), 64'd0);
    check_vec("rst_p", 64'(p), 64'd0);
    rst = 1'b0;

    // Directed products, latency and one-cycle out_valid pulse.
    for (int i = 0; i < 10; i++) begin
      run_op(dir_a[i], dir_b[i], pr, lat);
      check_vec($sformatf("dir%0d_p", i), 64'(pr), 64'(dir_p[i]));
      check_vec($sformatf("dir%0d_lat", i), 64'(lat), 64'd5);
      check_vec($sformatf("dir%0d_ov_drop", i), 64'(out_valid), 64'd0);
      check_vec($sformatf("dir%0d_rdy_back", i), 64'(in_ready), 64'd1);
    end

    // Back-pressure: product held for 10 cycles, new operands ignored.
    @(negedge clk);
    a = 16'h0010; b = 16'h0011; in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk); #1;
    a = 16'hFFFF; b = 16'hFFFF;
    t = 0;
    while (out_valid !== 1'b1 && t < 40) begin
      @(posedge clk); #1;
      t++;
    end
    check_vec("stall_lat", 64'(t), 64'd5);
    for (int i = 0; i < 10; i++) begin
      check_vec($sformatf("stall%0d_p", i), 64'(p), 64'h110);
      check_vec($sformatf("stall%0d_ov", i), 64'(out_valid), 64'd1);
      check_vec($sformatf("stall%0d_rdy", i), 64'(in_ready), 64'd0);
      @(posedge clk); #1;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    check_vec("stall_release_rdy", 64'(in_ready), 64'd1);
    check_vec("stall_release_ov", 64'(out_valid), 64'd0);

    // Reset during the second ACCUM cycle aborts the operation.
    @(negedge clk);
    a = 16'h1111; b = 16'h2222; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    check_vec("abort_busy_pre", 64'(busy), 64'd1);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check_vec("abort_rdy", 64'(in_ready), 64'd1);
    check_vec("abort_busy", 64'(busy), 64'd0);
    check_vec("abort_p", 64'(p), 64'd0);
    seen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      if (out_valid === 1'b1) seen = 1'b1;
      @(posedge clk); #1;
    end
    check_vec("abort_no_product", 64'(seen), 64'd0);
    run_op(16'hFFF9, 16'h0009, pr, lat);
    check_vec("after_abort_p", 64'(pr), 64'hFFFFFFC1);

    // Reset in DONE with out_ready=0 wins over a simultaneous out_ready.
    @(negedge clk);
    a = 16'h0002; b = 16'h0003; in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    t = 0;
    while (out_valid !== 1'b1 && t < 40) begin
      @(posedge clk); #1;
      t++;
    end
    check_vec("done_rst_p_pre", 64'(p), 64'd6);
    rst = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check_vec("done_rst_ov", 64'(out_valid), 64'd0);
    check_vec("done_rst_rdy", 64'(in_ready), 64'd1);
    check_vec("done_rst_p", 64'(p), 64'd0);

    // Back-to-back random operands with in_valid held high.
    in_valid  = 1'b1;
    out_ready = 1'b1;
    prev_c    = 0;
    for (int i = 0; i < 10000; i++) begin
      ai   = 16'($urandom);
      bi   = 16'($urandom);
      sa   = {{16{ai[15]}}, ai};
      sb   = {{16{bi[15]}}, bi};
      expv = 32'(sa * sb);
      t = 0;
      while (in_ready !== 1'b1 && t < 20) begin
        @(posedge clk); #1;
        t++;
      end
      a = ai;
      b = bi;
      @(posedge clk); #1;
      acc_c = cyc;
      if (i > 0) check_vec($sformatf("b2b%0d_spacing", i), 64'(acc_c - prev_c), 64'd7);
      prev_c = acc_c;
      a = 16'($urandom);
      b = 16'($urandom);
      t = 0;
      while (out_valid !== 1'b1 && t < 40) begin
        @(posedge clk); #1;
        t++;
      end
      check_vec($sformatf("b2b%0d_p a=%0h b=%0h", i, ai, bi), 64'(p), 64'(expv));
      @(posedge clk); #1;
    end
    in_valid = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/booth_seq_mul_ctrl.md
BOOTH_SEQ_MUL_CTRL -- requirements
Module: booth_seq_mul_ctrl

Interface
REQ-001 Parameter WIDTH, default 16, operand width in bits; SHALL be a multiple of 4 and at least 8.
REQ-002 clk  input  1  sole clock; all state SHALL update on the rising edge.
REQ-003 rst  input  1  reset, synchronous and active-high.
REQ-004 in_valid  input  1  operand pair present on a and b.
REQ-005 in_ready  output  1  block accepts an operand pair this cycle.
REQ-006 a  input  WIDTH  signed multiplicand.
REQ-007 b  input  WIDTH  signed multiplier, Booth-recoded.
REQ-008 out_valid  output  1  product valid on p.
REQ-009 out_ready  input  1  consumer accepts p this cycle.
REQ-010 p  output  2*WIDTH  signed product a*b, two's complement.
REQ-011 busy  output  1  high in every state except IDLE.

Function
REQ-012 FSM states SHALL be IDLE, ACCUM, RESOLVE and DONE.
REQ-013 IDLE: in_ready=1; on in_valid&in_ready, latch a and b, clear sum/carry vectors and the iteration counter, then go to ACCUM.
REQ-014 in_ready SHALL be 0 in ACCUM, RESOLVE and DONE; in_valid in those states SHALL be ignored.
REQ-015 Radix-4 Booth digit i (0..WIDTH/2-1) SHALL be taken from {b[2i+1], b[2i], b[2i-1]} with b[-1]=0, giving 0, +1, +2, -1 or -2.
REQ-016 Partial product i SHALL be digit_i*a sign-extended to 2*WIDTH and shifted left by 2i; negative digits are formed by full two's complement inside the cycle.
REQ-017 Each ACCUM cycle SHALL consume digits 2k and 2k+1 (k = iteration counter) and compress {sum, carry, pp_2k, pp_2k+1} through one 2*WIDTH-bit 4:2 compressor row into new sum and carry vectors.
REQ-018 The carry vector out of the row SHALL be shifted left by 1 with the MSB discarded; all arithmetic SHALL be modulo 2^(2*WIDTH).
REQ-019 ACCUM SHALL last exactly WIDTH/4 cycles, then go to RESOLVE.
REQ-020 RESOLVE SHALL register p = sum + carry (2*WIDTH-bit carry-propagate add, carry-out dropped) and go to DONE.
REQ-021 DONE: out_valid=1 and p held stable; when out_ready=1, go to IDLE; when out_ready=0, stay in DONE with p unchanged.
REQ-022 Latency from the accepting edge to the first cycle with out_valid=1 SHALL be WIDTH/4+1 cycles (5 for WIDTH=16); throughput is one product per WIDTH/4+3 cycles when out_ready is held high.
REQ-023 out_valid SHALL be 0 in IDLE, ACCUM and RESOLVE.
REQ-024 Operand registers SHALL NOT change between acceptance and the return to IDLE.
REQ-025 The most-negative operand (-2^(WIDTH-1)) on either input SHALL produce the exact product, with no saturation.

Reset
REQ-026 With rst=1 at a clock edge, the next state SHALL be IDLE, with out_valid=0, busy=0, in_ready=1, p=0, and sum, carry and the iteration counter all 0.
REQ-027 Reset asserted in any state, including mid-ACCUM and DONE with out_ready=0, SHALL abort the operation with no product delivered.
REQ-028 rst SHALL take priority over every handshake event in the same cycle.

Structure
REQ-029 Package booth_pkg SHALL hold the FSM state enum, the Booth digit encoding (ZERO, POS1, POS2, NEG1, NEG2) and the recode function from 3 multiplier bits.
REQ-030 The 2*WIDTH-bit 4:2 compressor row SHALL be a separate combinational sub-module, compressor_4_2_row, built from per-bit 4:2 compressor cells with an inter-column carry chain.
REQ-031 The FSM, iteration counter, operand, sum and carry registers and the final adder SHALL reside in booth_seq_mul_ctrl.

Verification (WIDTH=16)
REQ-032 a=3, b=5, out_ready=1 -> out_valid rises 5 cycles after acceptance with p=0x0000000F and is high for 1 cycle.
REQ-033 a=0x8000, b=0x8000 -> p=0x40000000; a=0xFFFF, b=0x0001 -> p=0xFFFFFFFF; a=0x7FFF, b=0x8000 -> p=0xC0008000.
REQ-034 out_ready held 0 for 10 cycles after out_valid -> p and out_valid stable, in_ready=0 throughout; product consumed on the first cycle out_ready=1, and in_ready=1 on the next cycle.
REQ-035 rst pulsed during the 2nd ACCUM cycle -> next cycle IDLE, out_valid never asserts; the following operation a=-7, b=9 gives p=0xFFFFFFC1.
REQ-036 Back-to-back operations with in_valid held high -> each accepted in IDLE only, one every 7 cycles; 10,000 random signed pairs match the reference model a*b exactly.
